pixel_reader: RTL and testbench

Read-side counterpart to the framebuffer pixel write path: accepts pixel addresses, issues 32-bit Avalon-MM reads to the framebuffer, and returns the addressed 16-bit pixel from each word. Address bit 0 selects the half-word (0 = bits [15:0], 1 = bits [31:16]), matching the write path's packing of two pixels per word. Sits between the raster/blend logic (the consumer for read-modify-write and copy operations) and the framebuffer memory master port. Supports up to MAX_OUTSTANDING pipelined reads with in-order return and backpressure on the pixel output.

---
 rtl/pixel_reader.sv | 140 ++++++++++++++
 tb/tb_pixel_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_reader.sv
// rtl/pixel_reader.sv - framebuffer pixel read path: Avalon-MM word reads, half-word pixel return
module pixel_reader_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= din;
    end
  end

  // Pointer update; push and pop in the same cycle are both honoured
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[PTR_W-1:0]];
endmodule

module pixel_reader #(
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-2:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [15:0]       pix_color,
  output logic              protocol_err
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [CNT_W-1:0] inflight;
  logic             req_fire;
  logic             pix_pop;
  logic             tag_empty;
  logic             tag_head;
  logic             tag_pop;
  logic             ret_empty;
  logic [15:0]      ret_head;
  logic [15:0]      ret_din;

  // inflight covers accept through delivery, so the return FIFO cannot overflow
  assign req_ready = ~reset & (~avm_read | ~avm_waitrequest)
                   & (inflight < CNT_W'(MAX_OUTSTANDING));
  assign req_fire  = req_valid & req_ready;
  assign pix_pop   = pix_valid & pix_ready;
  assign tag_pop   = avm_readdatavalid & ~tag_empty;
  assign ret_din   = tag_head ? avm_readdata[31:16] : avm_readdata[15:0];
  assign pix_valid = ~ret_empty;
  assign pix_color = ret_empty ? 16'h0000 : ret_head;

  // Command register: load on accept, drop read on completion, hold during waitrequest
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= 4'b0000;
    end else if (req_fire) begin
      avm_read       <= 1'b1;
      avm_address    <= req_addr[ADDR_W-1:1];
      avm_byteenable <= req_addr[0] ? 4'b1100 : 4'b0011;
    end else if (avm_read & ~avm_waitrequest) begin
      avm_read       <= 1'b0;
    end
  end

  // Slot counter: accept adds a slot, pixel delivery frees one
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({req_fire, pix_pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky flag for a data beat with no read outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if (avm_readdatavalid & tag_empty) begin
      protocol_err <= 1'b1;
    end
  end

  pixel_reader_fifo #(.W(1), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .din   (req_addr[0]),
    .pop   (tag_pop),
    .empty (tag_empty),
    .head  (tag_head)
  );

  pixel_reader_fifo #(.W(16), .DEPTH(MAX_OUTSTANDING)) u_ret_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_pop),
    .din   (ret_din),
    .pop   (pix_pop),
    .empty (ret_empty),
    .head  (ret_head)
  );
endmodule

// File: tb/tb_pixel_reader.sv
// tb/tb_pixel_reader.sv - directed self-checking bench for pixel_reader
module tb_pixel_reader;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [30:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_color;
  logic        protocol_err;

  logic        slave_rdv = 1'b0;
  logic [31:0] slave_data = 32'h0;
  logic        inj_rdv;
  logic [31:0] inj_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } beat_t;
  beat_t q[$];
  int    ecount = 0;

  assign avm_readdatavalid = slave_rdv | inj_rdv;
  assign avm_readdata      = inj_rdv ? inj_data : slave_data;

  pixel_reader dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .pix_color         (pix_color),
    .protocol_err      (protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_for(input logic [30:0] w);
    if (w == 31'd8) return 32'hBEEF_1234;
    return {4'hA, w[11:0], 4'h5, w[11:0]};
  endfunction

  function automatic logic [15:0] exp_pix(input int p);
    logic [11:0] w;
    w = 12'(p >> 1);
    return p[0] ? {4'hA, w} : {4'h5, w};
  endfunction

  // Memory slave model: returns data LAT cycles after each completed command, in order
  always @(posedge clk) begin
    ecount++;
    if (reset) begin
      q.delete();
      slave_rdv  <= 1'b0;
      slave_data <= 32'h0;
    end else begin
      if (avm_read && !avm_waitrequest) q.push_back('{ecount + LAT - 1, data_for(avm_address)});
      if (q.size() > 0 && q[0].due == ecount) begin
        slave_rdv  <= 1'b1;
        slave_data <= q[0].data;
        void'(q.pop_front());
      end else begin
        slave_rdv  <= 1'b0;
        slave_data <= 32'h0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic single_read(input logic [31:0] addr, input logic [3:0] be, input logic [15:0] color);
    req_valid = 1'b1;
    req_addr  = addr;
    pix_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("cmd_read", 32'(avm_read), 32'd1);
    chk("cmd_addr", 32'(avm_address), addr >> 1);
    chk("cmd_be", 32'(avm_byteenable), 32'(be));
    @(negedge clk);
    chk("cmd_done", 32'(avm_read), 32'd0);
    chk("pix_not_yet", 32'(pix_valid), 32'd0);
    @(negedge clk);
    chk("pix_valid", 32'(pix_valid), 32'd1);
    chk("pix_color", 32'(pix_color), 32'(color));
    @(negedge clk);
    chk("pix_gone", 32'(pix_valid), 32'd0);
    chk("pix_color_zero", 32'(pix_color), 32'd0);
  endtask

  initial begin
    int idx;
    int got;
    int bubbles;
    int acc;
    bit started;
    logic [31:0] a;

    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; avm_waitrequest = 1'b0;
    pix_ready = 1'b0; inj_rdv = 1'b0; inj_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_address", 32'(avm_address), 32'd0);
    chk("rst_avm_be", 32'(avm_byteenable), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_color", 32'(pix_color), 32'd0);
    chk("rst_protocol_err", 32'(protocol_err), 32'd0);
    reset = 1'b0;
    #1 chk("req_ready_after_reset", 32'(req_ready), 32'd1);

    // Single reads, both half-words
    single_read(32'h10, 4'b0011, 16'h1234);
    single_read(32'h11, 4'b1100, 16'hBEEF);

    // Waitrequest stall: 3 stalled cycles then completion
    avm_waitrequest = 1'b1; req_valid = 1'b1; req_addr = 32'h20; pix_ready = 1'b1;
    @(negedge clk);
    req_addr = 32'h22;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_read%0d", i), 32'(avm_read), 32'd1);
      chk($sformatf("stall_addr%0d", i), 32'(avm_address), 32'h10);
      chk($sformatf("stall_be%0d", i), 32'(avm_byteenable), 32'h3);
      chk($sformatf("stall_req_ready%0d", i), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    avm_waitrequest = 1'b0; req_valid = 1'b0;
    #1;
    chk("stall_final_read", 32'(avm_read), 32'd1);
    chk("stall_final_addr", 32'(avm_address), 32'h10);
    chk("stall_release_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("stall_done", 32'(avm_read), 32'd0);
    @(negedge clk);
    chk("stall_pix_valid", 32'(pix_valid), 32'd1);
    chk("stall_pix_color", 32'(pix_color), 32'h5010);
    @(negedge clk);
    chk("stall_one_pixel", 32'(pix_valid), 32'd0);

    // Pipelined burst, addresses 0..7
    idx = 0; got = 0; bubbles = 0; started = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 8) begin
        req_valid = 1'b1;
        req_addr  = 32'(idx);
        #1 if (req_ready) idx++;
      end else begin
        req_valid = 1'b0;
        #1;
      end
      if (pix_valid) begin
        if (got < 8) chk($sformatf("burst_pix%0d", got), 32'(pix_color), 32'(exp_pix(got)));
        got++;
        started = 1'b1;
      end else if (started && got < 8) begin
        bubbles++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("burst_accepts", 32'(idx), 32'd8);
    chk("burst_count", 32'(got), 32'd8);
    chk("burst_bubbles", 32'(bubbles), 32'd0);

    // Backpressure until full, then drain
    pix_ready = 1'b0; acc = 0; a = 32'h30;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1;
      req_addr  = a;
      #1 if (req_ready) begin acc++; a++; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("full_accepts", 32'(acc), 32'd4);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain_valid%0d", i), 32'(pix_valid), 32'd1);
      chk($sformatf("drain_color%0d", i), 32'(pix_color), 32'(exp_pix(32'h30 + i)));
      if (i == 0) chk("drain_ready_before_pop", 32'(req_ready), 32'd0);
      if (i == 1) chk("drain_ready_after_pop", 32'(req_ready), 32'd1);
      @(negedge clk);
    end
    chk("drain_empty", 32'(pix_valid), 32'd0);

    // Stray beat
    chk("pre_stray_err", 32'(protocol_err), 32'd0);
    inj_rdv = 1'b1; inj_data = 32'h1234_5678;
    @(negedge clk);
    inj_rdv = 1'b0;
    chk("stray_err", 32'(protocol_err), 32'd1);
    chk("stray_pix_valid", 32'(pix_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("stray_err_sticky", 32'(protocol_err), 32'd1);
    chk("stray_pix_still_0", 32'(pix_valid), 32'd0);

    // Reset with three reads in flight
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h40 + 32'(i);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("pre_reset_pix_valid", 32'(pix_valid), 32'd1);
    reset = 1'b1;
    #1 chk("reset_req_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("mid_rst_avm_read", 32'(avm_read), 32'd0);
    chk("mid_rst_avm_address", 32'(avm_address), 32'd0);
    chk("mid_rst_avm_be", 32'(avm_byteenable), 32'd0);
    chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("mid_rst_pix_color", 32'(pix_color), 32'd0);
    chk("mid_rst_protocol_err", 32'(protocol_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_avm_read", 32'(avm_read), 32'd0);
    repeat (3) @(negedge clk);
    chk("post_rst_no_late_pix", 32'(pix_valid), 32'd0);
    chk("post_rst_err_clear", 32'(protocol_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
